daq_sequencer: RTL

DAQ_SEQUENCER -- requirements
Module: daq_sequencer

---
 rtl/daq_pkg.sv | 35 +++
 rtl/trig_sync_edge.sv | 28 ++
 rtl/daq_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/daq_pkg.sv
// Shared state encoding, run-mode encodings and fixed pulse lengths for the DAQ sequencer.
// Declarations only: no latency, no flow control.
package daq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PWR_UP,
    ASIC_RST,
    ACQ,
    ARM,
    HOLD,
    READOUT,
    RAZ,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_AUTO    = 2'd0,
    MODE_SLAVE   = 2'd1,
    MODE_COUNTED = 2'd2,
    MODE_RSVD    = 2'd3
  } daq_mode_t;

  localparam int unsigned RSTB_CYC   = 4;
  localparam int unsigned RAZ_CYC    = 2;
  // Cycles a trigger edge spends in the synchroniser before the FSM can see it.
  localparam int unsigned TRIG_LAT   = 2;
  localparam logic [3:0]  PWR_ALL_ON = 4'hF;

  // True on the last cycle of a window of len cycles; len of 0 acts as 1.
  function automatic logic cnt_done(input logic [31:0] cnt, input logic [31:0] len);
    return (cnt + 32'd1) >= len;
  endfunction

endpackage

// File: rtl/trig_sync_edge.sv
// Two-flop synchroniser and rising-edge detector for the asynchronous external trigger.
// Latency: edge flag high for one cycle, two clocks after the input is first sampled high; no backpressure.
module trig_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_trig,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_trig;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/daq_sequencer.sv
// Run sequencer for daisy-chained acquisition ASICs: power pulsing, reset, acquire/trigger, readout handshake.
// Latency: one state per clock; no backpressure, the readout side is waited on through EndReadout.
module daq_sequencer
  import daq_pkg::*;
#(
  parameter int TIME_W     = 16,
  parameter int CNT_W      = 16,
  parameter int CHIP_NUM   = 4,
  parameter int SETTLE_CYC = 8
) (
  input  logic                Clk,
  input  logic                reset_n,
  input  logic [1:0]          DaqMode,
  input  logic                UsbAcqStart,
  input  logic                ExternalTrigger,
  input  logic [CHIP_NUM-1:0] CHIPSATB,
  input  logic                EndReadout,
  input  logic                UsbFifoEmpty,
  input  logic [TIME_W-1:0]   AcquisitionTime,
  input  logic [TIME_W-1:0]   EndHoldTime,
  input  logic [CNT_W-1:0]    TriggerLimit,
  output logic                RESET_B,
  output logic                START_ACQ,
  output logic [3:0]          PwrOn,
  output logic                ForceExternalRaz,
  output logic                StartReadout,
  output logic                OnceEnd,
  output logic                AllDone,
  output logic                UsbStartStop,
  output logic [CNT_W-1:0]    AcqCount
);

  state_t            r_state;
  daq_mode_t         r_mode;
  logic [TIME_W-1:0] r_cnt;
  logic [CNT_W-1:0]  r_acq_cnt;
  logic              r_start_d;
  logic              r_once;
  logic              r_usb;

  state_t            w_next;
  daq_mode_t         w_mode_in;
  logic              w_auto;
  logic              w_start_rise;
  logic              w_chip_full;
  logic              w_trig_rise;
  logic [CNT_W-1:0]  w_acq_next;

  trig_sync_edge u_trig (
    .i_clk   (Clk),
    .i_rst_n (reset_n),
    .i_trig  (ExternalTrigger),
    .o_rise  (w_trig_rise)
  );

  assign w_mode_in    = (DaqMode == MODE_RSVD) ? MODE_AUTO : daq_mode_t'(DaqMode);
  assign w_auto       = (r_mode == MODE_AUTO);
  assign w_start_rise = UsbAcqStart & ~r_start_d;
  assign w_chip_full  = ~&CHIPSATB;
  assign w_acq_next   = r_acq_cnt + 1'b1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_start_rise) w_next = PWR_UP;
      PWR_UP:   if (cnt_done(32'(r_cnt), 32'(SETTLE_CYC))) w_next = ASIC_RST;
      ASIC_RST: if (cnt_done(32'(r_cnt), RSTB_CYC)) w_next = w_auto ? ACQ : ARM;
      ACQ:      if (!UsbAcqStart || w_chip_full || cnt_done(32'(r_cnt), 32'(AcquisitionTime)))
                  w_next = READOUT;
      // Edges seen in the first TRIG_LAT cycles of ARM were launched before ARM began.
      ARM:      if (!UsbAcqStart) w_next = IDLE;
                else if (w_trig_rise && (32'(r_cnt) >= TRIG_LAT)) w_next = HOLD;
      HOLD:     if (!UsbAcqStart || w_chip_full || cnt_done(32'(r_cnt), 32'(EndHoldTime)))
                  w_next = READOUT;
      READOUT:  if (EndReadout) begin
                  if (!UsbAcqStart) w_next = IDLE;
                  else if (r_mode == MODE_COUNTED && TriggerLimit != '0 && w_acq_next == TriggerLimit)
                    w_next = DONE;
                  else if (w_auto) w_next = PWR_UP;
                  else w_next = RAZ;
                end
      RAZ:      if (cnt_done(32'(r_cnt), RAZ_CYC)) w_next = ARM;
      DONE:     if (!UsbAcqStart) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_mode    <= MODE_AUTO;
      r_cnt     <= '0;
      r_acq_cnt <= '0;
      r_start_d <= 1'b0;
      r_once    <= 1'b0;
      r_usb     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_start_d <= UsbAcqStart;
      r_cnt     <= (w_next != r_state) ? '0 : ((&r_cnt) ? r_cnt : r_cnt + 1'b1);
      r_once    <= 1'b0;
      if (r_state == IDLE && w_start_rise) begin
        r_mode    <= w_mode_in;
        r_acq_cnt <= '0;
      end
      if (r_state == READOUT && EndReadout) begin
        r_acq_cnt <= w_acq_next;
        r_once    <= 1'b1;
      end
      // A new run request outranks a clear that would otherwise land in the same IDLE cycle.
      if (r_state == IDLE && w_start_rise) r_usb <= 1'b1;
      else if ((r_state == IDLE || r_state == DONE) && UsbFifoEmpty) r_usb <= 1'b0;
    end
  end

  assign RESET_B          = (r_state != ASIC_RST);
  assign START_ACQ        = (r_state == ACQ) || (r_state == ARM) || (r_state == HOLD);
  assign PwrOn            = (r_state == IDLE || r_state == DONE) ? 4'h0 : PWR_ALL_ON;
  assign ForceExternalRaz = (r_state == RAZ);
  assign StartReadout     = (r_state == READOUT) && (r_cnt == '0);
  assign AllDone          = (r_state == DONE);
  assign OnceEnd          = r_once;
  assign UsbStartStop     = r_usb;
  assign AcqCount         = r_acq_cnt;

endmodule
